// File: rtl/mbist_march_ctrl_if.sv
// RAM-side bus of the March C- MBIST controller.
// master: controller side; slave: RAM / test-mode mux side.
interface mbist_march_ctrl_if #(
    parameter int ADDR   = 6,
    parameter int DATA_W = 4
);
    logic              mem_cs;
    logic              mem_we;
    logic              mem_oe;
    logic [ADDR-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_d_in;
    logic [DATA_W-1:0] mem_d_out;

    modport master (
        output mem_cs, mem_we, mem_oe, mem_addr, mem_d_in,
        input  mem_d_out
    );

    modport slave (
        input  mem_cs, mem_we, mem_oe, mem_addr, mem_d_in,
        output mem_d_out
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// Word-oriented March C- MBIST controller.
// Runs March C- once per data background (all-zeros plus one checkerboard
// per address bit of the word), compares reads one cycle after issue and
// reports sticky pass/fail.
// Optional macro MBIST_DIAG_EN: enables first-fault diagnostics
// (diag_addr/diag_bg/diag_elem/diag_mask) and the saturating fail_cnt;
// without it those ports are tied to zero.
module mbist_march_ctrl #(
    parameter  int ADDR   = 6,
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 8,
    localparam int NBG    = $clog2(DATA_W) + 1,
    localparam int BG_W   = (NBG > 1) ? $clog2(NBG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    mbist_march_ctrl_if.master  mem,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [ADDR-1:0]     diag_addr,
    output logic [BG_W-1:0]     diag_bg,
    output logic [2:0]          diag_elem,
    output logic [DATA_W-1:0]   diag_mask,
    output logic [CNT_W-1:0]    fail_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [BG_W-1:0]   bg;
    logic [2:0]        elem;
    logic [ADDR-1:0]   addr;
    logic              ph;       // 0: read half, 1: write half of a (r,w) element
    logic              fin;      // last op has been issued

    logic              cmp_vld;
    logic [DATA_W-1:0] cmp_exp;
`ifdef MBIST_DIAG_EN
    logic [ADDR-1:0]   cmp_addr;
    logic [BG_W-1:0]   cmp_bg;
    logic [2:0]        cmp_elem;
`endif

    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] op_data;
    logic              op_rd;
    logic              is_rw;
    logic              down;
    logic              step;
    logic              elem_end;
    logic              last_bg;
    logic              last_op;
    logic [ADDR-1:0]   nxt_addr;
    logic [2:0]        nxt_elem;
    logic [BG_W-1:0]   nxt_bg;
    logic              nxt_ph;

    // Background b>=1: bit i of the word is bit (b-1) of i.
    function automatic logic [DATA_W-1:0] bg_pattern(input logic [BG_W-1:0] b);
        logic [DATA_W-1:0] p;
        int unsigned       sh;
        p = '0;
        if (b != '0) begin
            sh = 32'(b) - 32'd1;
            for (int unsigned i = 0; i < DATA_W; i++)
                p[i] = ((i >> sh) & 32'd1) != 32'd0;
        end
        return p;
    endfunction

    // Decode the op for the current sequencer position and its successor.
    always_comb begin
        pat   = bg_pattern(bg);
        is_rw = (elem >= 3'd1) && (elem <= 3'd4);
        op_rd = (elem == 3'd5) || (is_rw && !ph);
        down  = (elem == 3'd3) || (elem == 3'd4);

        if (op_rd)
            op_data = ((elem == 3'd2) || (elem == 3'd4)) ? ~pat : pat;
        else
            op_data = ((elem == 3'd1) || (elem == 3'd3)) ? ~pat : pat;

        // The address only moves after the last op issued at it.
        step     = !(is_rw && !ph);
        elem_end = step && (down ? (addr == '0) : (addr == '1));
        last_bg  = (bg == BG_W'(NBG - 1));
        last_op  = elem_end && (elem == 3'd5) && last_bg;

        nxt_ph   = is_rw && !ph;
        nxt_addr = addr;
        nxt_elem = elem;
        nxt_bg   = bg;
        if (elem_end) begin
            if (elem == 3'd5) begin
                nxt_elem = 3'd0;
                nxt_bg   = bg + 1'b1;
            end else begin
                nxt_elem = elem + 3'd1;
            end
            nxt_addr = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? '1 : '0;
        end else if (step) begin
            nxt_addr = down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    // Control FSM, op issue, and the one-stage read compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bg           <= '0;
            elem         <= '0;
            addr         <= '0;
            ph           <= 1'b0;
            fin          <= 1'b0;
            mem.mem_cs   <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_oe   <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_d_in <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            cmp_vld      <= 1'b0;
            cmp_exp      <= '0;
`ifdef MBIST_DIAG_EN
            cmp_addr     <= '0;
            cmp_bg       <= '0;
            cmp_elem     <= '0;
            diag_addr    <= '0;
            diag_bg      <= '0;
            diag_elem    <= '0;
            diag_mask    <= '0;
            fail_cnt     <= '0;
`endif
        end else begin
            cmp_vld <= 1'b0;
            if (cmp_vld && (mem.mem_d_out != cmp_exp)) begin
                fail <= 1'b1;
`ifdef MBIST_DIAG_EN
                if (fail_cnt != '1)
                    fail_cnt <= fail_cnt + 1'b1;
                if (!fail) begin
                    diag_addr <= cmp_addr;
                    diag_bg   <= cmp_bg;
                    diag_elem <= cmp_elem;
                    diag_mask <= cmp_exp ^ mem.mem_d_out;
                end
`endif
            end

            // A start accepted here overrides any compare result on the same edge.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        bg    <= '0;
                        elem  <= '0;
                        addr  <= '0;
                        ph    <= 1'b0;
                        fin   <= 1'b0;
                        done  <= 1'b0;
                        fail  <= 1'b0;
`ifdef MBIST_DIAG_EN
                        diag_addr <= '0;
                        diag_bg   <= '0;
                        diag_elem <= '0;
                        diag_mask <= '0;
                        fail_cnt  <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (fin) begin
                        mem.mem_cs <= 1'b0;
                        mem.mem_we <= 1'b0;
                        mem.mem_oe <= 1'b0;
                        state      <= S_DRAIN;
                        fin        <= 1'b0;
                    end else begin
                        mem.mem_cs   <= 1'b1;
                        mem.mem_we   <= !op_rd;
                        mem.mem_oe   <= op_rd;
                        mem.mem_addr <= addr;
                        mem.mem_d_in <= op_rd ? '0 : op_data;
                        busy         <= 1'b1;
                        if (op_rd) begin
                            cmp_vld  <= 1'b1;
                            cmp_exp  <= op_data;
`ifdef MBIST_DIAG_EN
                            cmp_addr <= addr;
                            cmp_bg   <= bg;
                            cmp_elem <= elem;
`endif
                        end
                        addr <= nxt_addr;
                        elem <= nxt_elem;
                        bg   <= nxt_bg;
                        ph   <= nxt_ph;
                        if (last_op)
                            fin <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef MBIST_DIAG_EN
    assign diag_addr = '0;
    assign diag_bg   = '0;
    assign diag_elem = '0;
    assign diag_mask = '0;
    assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl (ADDR=6, DATA_W=4, CNT_W=8).
// A behavioural March C- model fills an op scoreboard and a result
// scoreboard per run; a bus monitor pops ops, the main sequence pops results.
module tb_mbist_march_ctrl;
    localparam int ADDR   = 6;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;
    localparam int BG_W   = 2;
    localparam int SIZE   = 64;
    localparam int T_RUN  = 1922;

    typedef struct packed {
        logic              we;
        logic              oe;
        logic [ADDR-1:0]   addr;
        logic [DATA_W-1:0] data;
    } op_t;

    typedef struct {
        logic              f;
        int                cnt;
        logic [ADDR-1:0]   da;
        logic [BG_W-1:0]   db;
        logic [2:0]        de;
        logic [DATA_W-1:0] dm;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, fail;
    logic [ADDR-1:0]   diag_addr;
    logic [BG_W-1:0]   diag_bg;
    logic [2:0]        diag_elem;
    logic [DATA_W-1:0] diag_mask;
    logic [CNT_W-1:0]  fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    op_t  exp_ops[$];
    res_t exp_res[$];
    int   op_err = 0;
    int   op_idx = 0;
    int   bad_idx = -1;

    int                fault_mode = 0;
    logic [DATA_W-1:0] ram [SIZE];
    logic [DATA_W-1:0] mdl [SIZE];
    logic [DATA_W-1:0] pats [3] = '{4'b0000, 4'b1010, 4'b1100};
    int                m_cnt;

    mbist_march_ctrl_if #(.ADDR(ADDR), .DATA_W(DATA_W)) mem_if ();

    mbist_march_ctrl #(.ADDR(ADDR), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .diag_addr (diag_addr),
        .diag_bg   (diag_bg),
        .diag_elem (diag_elem),
        .diag_mask (diag_mask),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    // Mode 1: bit 2 stuck-at-1 at 0x15. Mode 2: AND-bridge of bits 0,1 at 0x3F.
    function automatic logic [DATA_W-1:0] fault_wr(input int mode, input logic [ADDR-1:0] a,
                                                   input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (mode == 1 && a == 6'h15) r[2] = 1'b1;
        if (mode == 2 && a == 6'h3F) begin
            r[0] = d[0] & d[1];
            r[1] = d[0] & d[1];
        end
        return r;
    endfunction

    // RAM: write on the edge, read data presented during the read op cycle.
    always @(posedge clk)
        if (mem_if.mem_cs && mem_if.mem_we)
            ram[mem_if.mem_addr] <= fault_wr(fault_mode, mem_if.mem_addr, mem_if.mem_d_in);

    assign mem_if.mem_d_out = (mem_if.mem_cs && mem_if.mem_oe) ? ram[mem_if.mem_addr] : '0;

    // Bus monitor: every op on the bus must match the next scoreboard entry.
    always @(negedge clk) begin : mon
        op_t e;
        if (rst) begin
            exp_ops.delete();
        end else if (mem_if.mem_cs) begin
            if (exp_ops.size() == 0) begin
                if (op_err == 0) bad_idx = op_idx;
                op_err++;
            end else begin
                e = exp_ops.pop_front();
                if (mem_if.mem_we !== e.we || mem_if.mem_oe !== e.oe ||
                    mem_if.mem_addr !== e.addr || (e.we && mem_if.mem_d_in !== e.data)) begin
                    if (op_err == 0) bad_idx = op_idx;
                    op_err++;
                end
            end
            op_idx++;
        end else if (mem_if.mem_we !== 1'b0 || mem_if.mem_oe !== 1'b0) begin
            if (op_err == 0) bad_idx = op_idx;
            op_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".fail"}, fail, 0);
        chk({tag, ".mem_cs"}, mem_if.mem_cs, 0);
        chk({tag, ".mem_we"}, mem_if.mem_we, 0);
        chk({tag, ".mem_oe"}, mem_if.mem_oe, 0);
        chk({tag, ".mem_addr"}, mem_if.mem_addr, 0);
        chk({tag, ".mem_d_in"}, mem_if.mem_d_in, 0);
        chk({tag, ".diag_addr"}, diag_addr, 0);
        chk({tag, ".diag_bg"}, diag_bg, 0);
        chk({tag, ".diag_elem"}, diag_elem, 0);
        chk({tag, ".diag_mask"}, diag_mask, 0);
        chk({tag, ".fail_cnt"}, fail_cnt, 0);
    endtask

    task automatic m_wr(input int a, input logic [DATA_W-1:0] d);
        exp_ops.push_back('{we: 1'b1, oe: 1'b0, addr: ADDR'(a), data: d});
        mdl[a] = fault_wr(fault_mode, ADDR'(a), d);
    endtask

    task automatic m_rd(input int a, input logic [DATA_W-1:0] d);
        exp_ops.push_back('{we: 1'b0, oe: 1'b1, addr: ADDR'(a), data: '0});
        if (mdl[a] !== d) m_cnt++;
    endtask

    // Behavioural March C- over all backgrounds; pushes ops and the final result.
    task automatic run_model();
        logic [DATA_W-1:0] p;
        int a;
        res_t r;
        m_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            p = pats[b];
            for (int e = 0; e < 6; e++) begin
                for (int k = 0; k < SIZE; k++) begin
                    a = (e == 3 || e == 4) ? SIZE - 1 - k : k;
                    case (e)
                        0: m_wr(a, p);
                        1: begin m_rd(a, p);  m_wr(a, ~p); end
                        2: begin m_rd(a, ~p); m_wr(a, p);  end
                        3: begin m_rd(a, p);  m_wr(a, ~p); end
                        4: begin m_rd(a, ~p); m_wr(a, p);  end
                        default: m_rd(a, p);
                    endcase
                end
            end
        end
        r.f  = (m_cnt > 0);
        r.cnt = 0; r.da = '0; r.db = '0; r.de = '0; r.dm = '0;
`ifdef MBIST_DIAG_EN
        r.cnt = (m_cnt > 255) ? 255 : m_cnt;
        if (fault_mode == 1) begin
            r.da = 6'h15; r.db = 2'd0; r.de = 3'd1; r.dm = 4'b0100;
        end else if (fault_mode == 2) begin
            r.da = 6'h3F; r.db = 2'd1; r.de = 3'd1; r.dm = 4'b0010;
        end
`endif
        exp_res.push_back(r);
    endtask

    task automatic do_run(input int fm, input string tag, input bit poke);
        res_t r;
        int   lat;
        int   err0;
        fault_mode = fm;
        run_model();
        err0 = op_err;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".k_busy"}, busy, 0);
        chk({tag, ".k_done"}, done, 0);
        chk({tag, ".k_fail"}, fail, 0);
        chk({tag, ".k_cs"}, mem_if.mem_cs, 0);
        tick();
        lat = 1;
        chk({tag, ".k1_busy"}, busy, 1);
        chk({tag, ".k1_cs"}, mem_if.mem_cs, 1);
        while (!done && lat < T_RUN + 50) begin
            start = poke && (lat == 500 || lat == T_RUN - 1);
            tick();
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, lat, T_RUN);
        chk({tag, ".busy_at_done"}, busy, 0);
        r = exp_res.pop_front();
        chk({tag, ".fail"}, fail, r.f);
        chk({tag, ".fail_cnt"}, fail_cnt, r.cnt);
        chk({tag, ".diag_addr"}, diag_addr, r.da);
        chk({tag, ".diag_bg"}, diag_bg, r.db);
        chk({tag, ".diag_elem"}, diag_elem, r.de);
        chk({tag, ".diag_mask"}, diag_mask, r.dm);
        chk({tag, ".op_errors"}, op_err - err0, 0);
        if (op_err != err0) $display("  first bad op index %0d", bad_idx);
        chk({tag, ".ops_left"}, exp_ops.size(), 0);
        if (poke) begin
            tick();
            chk({tag, ".drain_start_done"}, done, 1);
            chk({tag, ".drain_start_busy"}, busy, 0);
            chk({tag, ".drain_start_cs"}, mem_if.mem_cs, 0);
        end
    endtask

    initial begin
        res_t r;
        int   err0;

        rst = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        do_run(0, "clean", 1'b1);
        do_run(1, "stuck", 1'b0);

        chk("stuck.done_sticky", done, 1);
        chk("stuck.fail_sticky", fail, 1);
        do_run(2, "bridge", 1'b0);

        // Interrupt a bridge-fault run inside element 3 of background 1.
        fault_mode = 2;
        run_model();
        err0 = op_err;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (1000) tick();
        chk("midrst.busy_before", busy, 1);
        chk("midrst.fail_before", fail, 1);
        chk("midrst.op_errors", op_err - err0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        r = exp_res.pop_front();
        chk("midrst.ops_flushed", exp_ops.size(), 0);
        tick();
        chk_zero("midrst_idle");

        do_run(0, "rerun", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
